// File: rtl/io_pattern_tester.sv
// IO bank bring-up pattern generator: COUNT, WALK, LFSR and paired-pin LOOPBACK.
// Define IOPT_FAIL_MASK_EN to build per-pin failure accumulation into fail_mask.
module io_pattern_tester #(
  parameter int NUM_IO  = 31,
  parameter int DIV_W   = 8,
  parameter int RUN_LEN = 256,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [DIV_W-1:0]  div,
  input  logic [NUM_IO-1:0] io_in,
  output logic [NUM_IO-1:0] io_out,
  output logic [NUM_IO-1:0] io_oeb,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  err_cnt,
  output logic [NUM_IO-1:0] fail_mask
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [1:0]  M_COUNT = 2'd0;
  localparam logic [1:0]  M_WALK  = 2'd1;
  localparam logic [1:0]  M_LFSR  = 2'd2;
  localparam logic [1:0]  M_LOOP  = 2'd3;
  localparam logic [31:0] TAPS    = 32'h8020_0003;
  localparam int          WI_W    = $clog2(NUM_IO);

  function automatic logic [NUM_IO-1:0] odd_bits();
    logic [NUM_IO-1:0] m;
    m = '0;
    for (int i = 1; i < NUM_IO; i += 2) m[i] = 1'b1;
    return m;
  endfunction

  localparam logic [NUM_IO-1:0] ODD  = odd_bits();
  localparam logic [NUM_IO-1:0] EVEN = ~odd_bits();

  state_t           state;
  logic [1:0]       mode_q;
  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] divcnt;
  logic [31:0]      step;
  logic [31:0]      lfsr;
  logic [WI_W-1:0]  widx;

  logic              tick, last, mis_any;
  logic [31:0]       step_n, lfsr_n;
  logic [NUM_IO-1:0] pair_mis;

  assign tick   = (state == RUN) && (divcnt == div_q);
  assign step_n = step + 32'd1;
  assign last   = (step_n == 32'(RUN_LEN));
  assign lfsr_n = lfsr[0] ? ((lfsr >> 1) ^ TAPS) : (lfsr >> 1);

  // Odd pin 2k+1 is jumpered from even pin 2k; the top pin of an odd-sized bank is never checked.
  assign pair_mis = (io_in ^ {io_out[NUM_IO-2:0], 1'b0}) & ODD;
  // Step 0 means this is the first tick: pads have not yet carried a pattern.
  assign mis_any  = (mode_q == M_LOOP) && (step != 32'd0) && (|pair_mis);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      mode_q  <= M_COUNT;
      div_q   <= '0;
      divcnt  <= '0;
      step    <= '0;
      lfsr    <= 32'h1;
      widx    <= '0;
      io_out  <= '0;
      io_oeb  <= '1;
      busy    <= 1'b0;
      done    <= 1'b0;
      err_cnt <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state   <= RUN;
            mode_q  <= mode;
            div_q   <= div;
            divcnt  <= '0;
            step    <= '0;
            lfsr    <= 32'h1;
            widx    <= '0;
            err_cnt <= '0;
            busy    <= 1'b1;
            done    <= 1'b0;
          end
        end
        RUN: begin
          divcnt <= tick ? '0 : divcnt + 1'b1;
          if (tick) begin
            step <= step_n;
            lfsr <= lfsr_n;
            widx <= (widx == WI_W'(NUM_IO - 1)) ? '0 : widx + 1'b1;
            if (mis_any && (err_cnt != '1)) err_cnt <= err_cnt + 1'b1;
            if (last) begin
              state  <= DONE;
              busy   <= 1'b0;
              done   <= 1'b1;
              io_out <= '0;
              io_oeb <= '1;
            end else begin
              case (mode_q)
                M_COUNT: begin io_out <= step_n[NUM_IO-1:0];          io_oeb <= '0;  end
                M_WALK:  begin io_out <= NUM_IO'(1) << widx;          io_oeb <= '0;  end
                M_LFSR:  begin io_out <= lfsr_n[NUM_IO-1:0];          io_oeb <= '0;  end
                default: begin io_out <= lfsr_n[NUM_IO-1:0] & EVEN;   io_oeb <= ODD; end
              endcase
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef IOPT_FAIL_MASK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      fail_mask <= '0;
    else if (state != RUN && start)
      fail_mask <= '0;
    else if (tick && mode_q == M_LOOP && step != 32'd0)
      fail_mask <= fail_mask | pair_mis;
  end
`else
  assign fail_mask = '0;
`endif

endmodule

// File: tb/tb_io_pattern_tester.sv
// Scoreboard bench for io_pattern_tester: per-step expected pad values are queued at start.
module tb_io_pattern_tester;
  localparam int NUM_IO  = 31;
  localparam int DIV_W   = 8;
  localparam int RUN_LEN = 256;
  localparam int CNT_W   = 16;

  localparam logic [1:0]  M_COUNT = 2'd0;
  localparam logic [1:0]  M_WALK  = 2'd1;
  localparam logic [1:0]  M_LFSR  = 2'd2;
  localparam logic [1:0]  M_LOOP  = 2'd3;
  localparam logic [31:0] TAPS    = 32'h8020_0003;
  localparam logic [NUM_IO-1:0] ODD  = 31'h2AAA_AAAA;
  localparam logic [NUM_IO-1:0] EVEN = 31'h5555_5555;

  typedef struct {
    logic [NUM_IO-1:0] out;
    logic [NUM_IO-1:0] oeb;
  } exp_t;

  logic              clk, rst_n, start;
  logic [1:0]        mode;
  logic [DIV_W-1:0]  div;
  logic [NUM_IO-1:0] io_in, io_out, io_oeb, fail_mask;
  logic              busy, done;
  logic [CNT_W-1:0]  err_cnt;

  logic              use_rnd, stick5;
  logic [NUM_IO-1:0] rnd_in;

  int   checks, errors;
  exp_t sb[$];

  io_pattern_tester #(
    .NUM_IO(NUM_IO), .DIV_W(DIV_W), .RUN_LEN(RUN_LEN), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .div(div),
    .io_in(io_in), .io_out(io_out), .io_oeb(io_oeb), .busy(busy), .done(done),
    .err_cnt(err_cnt), .fail_mask(fail_mask)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // External jumpers 2k -> 2k+1, with an optional stuck-at-0 fault on pin 5.
  always_comb begin
    io_in = '0;
    if (use_rnd) io_in = rnd_in;
    else begin
      for (int i = 1; i < NUM_IO; i += 2) io_in[i] = io_out[i-1];
      if (stick5) io_in[5] = 1'b0;
    end
  end

  task automatic push_exp(input logic [1:0] m);
    logic [31:0] l;
    exp_t e;
    l = 32'h1;
    sb.delete();
    for (int k = 1; k <= RUN_LEN; k++) begin
      l = l[0] ? ((l >> 1) ^ TAPS) : (l >> 1);
      case (m)
        M_COUNT: begin e.out = NUM_IO'(k);                    e.oeb = '0;  end
        M_WALK:  begin e.out = NUM_IO'(1) << ((k-1) % NUM_IO); e.oeb = '0;  end
        M_LFSR:  begin e.out = l[NUM_IO-1:0];                 e.oeb = '0;  end
        default: begin e.out = l[NUM_IO-1:0] & EVEN;          e.oeb = ODD; end
      endcase
      if (k == RUN_LEN) begin e.out = '0; e.oeb = '1; end
      sb.push_back(e);
    end
  endtask

  task automatic pulse_start(input logic [1:0] m, input logic [DIV_W-1:0] dv);
    @(negedge clk);
    mode  = m;
    div   = dv;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset();
    use_rnd = 1'b1;
    rnd_in  = NUM_IO'($urandom);
    mode    = 2'($urandom);
    div     = DIV_W'($urandom);
    start   = 1'($urandom);
    rst_n   = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (io_oeb !== 31'h7FFF_FFFF) begin errors++; $display("FAIL reset_oeb got %h exp 7fffffff", io_oeb); end
    checks++; if (io_out !== '0) begin errors++; $display("FAIL reset_out got %h exp 0", io_out); end
    checks++; if ({busy, done} !== 2'b00) begin errors++; $display("FAIL reset_busy_done got %b exp 00", {busy, done}); end
    checks++; if (err_cnt !== '0 || fail_mask !== '0) begin errors++; $display("FAIL reset_err got %h/%h exp 0/0", err_cnt, fail_mask); end
    start   = 1'b0;
    use_rnd = 1'b0;
    rst_n   = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_count();
    exp_t e;
    push_exp(M_COUNT);
    pulse_start(M_COUNT, 8'd3);
    mode = M_LFSR;
    div  = 8'd0;
    checks++; if ({busy, done} !== 2'b10) begin errors++; $display("FAIL count_busy got %b exp 10", {busy, done}); end
    for (int k = 1; k <= RUN_LEN; k++) begin
      repeat (4) @(negedge clk);
      e = sb.pop_front();
      checks++;
      if (io_out !== e.out || io_oeb !== e.oeb) begin
        errors++; $display("FAIL count_step%0d got %h/%h exp %h/%h", k, io_out, io_oeb, e.out, e.oeb);
      end
      if (k == RUN_LEN - 1) begin
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL count_early_done got %b exp 0", done); end
      end
    end
    checks++; if ({busy, done} !== 2'b01) begin errors++; $display("FAIL count_done got %b exp 01", {busy, done}); end
  endtask

  task automatic test_lfsr();
    exp_t e;
    logic [NUM_IO-1:0] hand [3];
    hand[0] = 31'h0020_0003;
    hand[1] = 31'h4030_0002;
    hand[2] = 31'h6018_0001;
    push_exp(M_LFSR);
    pulse_start(M_LFSR, 8'd0);
    for (int k = 1; k <= RUN_LEN; k++) begin
      if (k == RUN_LEN) start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      e = sb.pop_front();
      checks++;
      if (io_out !== e.out || io_oeb !== e.oeb) begin
        errors++; $display("FAIL lfsr_step%0d got %h/%h exp %h/%h", k, io_out, io_oeb, e.out, e.oeb);
      end
      if (k <= 3) begin
        checks++; if (io_out !== hand[k-1]) begin errors++; $display("FAIL lfsr_seed%0d got %h exp %h", k, io_out, hand[k-1]); end
      end
    end
    // A start coinciding with the final tick must not restart the run.
    repeat (2) @(negedge clk);
    checks++; if ({busy, done} !== 2'b01) begin errors++; $display("FAIL lfsr_final_start got %b exp 01", {busy, done}); end
  endtask

  task automatic test_loopback();
    exp_t e;
    int   exp_err;
    exp_err = 0;
    push_exp(M_LOOP);
    pulse_start(M_LOOP, 8'd1);
    for (int k = 1; k <= RUN_LEN; k++) begin
      repeat (2) @(negedge clk);
      e = sb.pop_front();
      checks++;
      if (io_out !== e.out || io_oeb !== e.oeb) begin
        errors++; $display("FAIL loop_step%0d got %h/%h exp %h/%h", k, io_out, io_oeb, e.out, e.oeb);
      end
      if (k == 19) begin
        checks++; if (err_cnt !== '0) begin errors++; $display("FAIL loop_clean got %0d exp 0", err_cnt); end
      end
      // Ticks 20..29 see pin 5 stuck low; each fails only when pin 4 is driving 1.
      stick5 = (k >= 19 && k <= 28);
      if (stick5 && e.out[4]) exp_err++;
    end
    stick5 = 1'b0;
    checks++; if (err_cnt !== CNT_W'(exp_err)) begin errors++; $display("FAIL loop_err got %0d exp %0d", err_cnt, exp_err); end
`ifdef IOPT_FAIL_MASK_EN
    checks++; if (fail_mask !== ((exp_err > 0) ? NUM_IO'(32'h20) : '0)) begin errors++; $display("FAIL loop_mask got %h exp %h", fail_mask, (exp_err > 0) ? 32'h20 : 32'h0); end
`else
    checks++; if (fail_mask !== '0) begin errors++; $display("FAIL loop_mask got %h exp 0", fail_mask); end
`endif
    repeat (3) @(negedge clk);
    checks++; if (err_cnt !== CNT_W'(exp_err) || done !== 1'b1) begin errors++; $display("FAIL loop_hold got %0d/%b exp %0d/1", err_cnt, done, exp_err); end
  endtask

  task automatic test_mid_run();
    exp_t e;
    push_exp(M_COUNT);
    pulse_start(M_COUNT, 8'd0);
    for (int k = 1; k <= 100; k++) begin
      start = (k == 50);
      if (k == 50) begin mode = M_WALK; div = 8'd5; end
      @(negedge clk);
      start = 1'b0;
      e = sb.pop_front();
      checks++;
      if (io_out !== e.out || io_oeb !== e.oeb) begin
        errors++; $display("FAIL mid_step%0d got %h/%h exp %h/%h", k, io_out, io_oeb, e.out, e.oeb);
      end
    end
    rst_n = 1'b0;
    #1;
    checks++; if (io_out !== '0 || io_oeb !== '1) begin errors++; $display("FAIL abort_pads got %h/%h exp 0/7fffffff", io_out, io_oeb); end
    checks++; if ({busy, done} !== 2'b00 || err_cnt !== '0) begin errors++; $display("FAIL abort_state got %b/%0d exp 00/0", {busy, done}, err_cnt); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL abort_no_done got %b exp 0", done); end
  endtask

  task automatic test_walk();
    exp_t e;
    push_exp(M_WALK);
    pulse_start(M_WALK, 8'd0);
    for (int k = 1; k <= RUN_LEN; k++) begin
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if (io_out !== e.out || io_oeb !== e.oeb) begin
        errors++; $display("FAIL walk_step%0d got %h/%h exp %h/%h", k, io_out, io_oeb, e.out, e.oeb);
      end
      if (k == 31) begin
        checks++; if (io_out !== 31'h4000_0000) begin errors++; $display("FAIL walk_top got %h exp 40000000", io_out); end
      end
      if (k == 32) begin
        checks++; if (io_out !== 31'h1) begin errors++; $display("FAIL walk_wrap got %h exp 1", io_out); end
      end
    end
    checks++; if ({busy, done} !== 2'b01) begin errors++; $display("FAIL walk_done got %b exp 01", {busy, done}); end
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    rst_n   = 1'b0;
    start   = 1'b0;
    mode    = '0;
    div     = '0;
    use_rnd = 1'b1;
    stick5  = 1'b0;
    rnd_in  = '0;
    test_reset();
    test_count();
    test_lfsr();
    test_loopback();
    test_mid_run();
    test_walk();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
